io_reset_ctl: RTL and testbench
===============================

// Module: io_reset_ctl
// PURPOSE
//  Pin-ring and core-reset controller between the pads and the Propeller core, generalising the top-level reset and bidir logic.
//  Synchronises pad inputs, registers pin outputs/enables, and latches per-pin change events.
//  Stretches core reset after the external reset or a cfg reset request (cfg[7]).
//  Pad tristate buffers stay in the top level; this block drives their data and enable.
// PARAMETERS
//  NPINS        32    number of I/O pins
//  SYNC_STAGES  2     input synchroniser depth (>=2)
//  HOLD_W       24    width of reset-hold counter
//  HOLD_CYCLES  1024  core_nres low time after all reset sources release (< 2**HOLD_W)
// PORTS
//  clk_cog     in   1      single clock for all logic
//  nres        in   1      reset, synchronous, active-low
//  cfg_rst     in   1      core reset request (cfg[7]), level, sampled on clk_cog
//  core_nres   out  1      stretched core reset, active-low, registered
//  pin_out     in   NPINS  core output data
//  pin_dir     in   NPINS  core direction, 1 = drive
//  pin_in      out  NPINS  synchronised pad input to core
//  pad_in      in   NPINS  raw asynchronous pad input
//  pad_out     out  NPINS  registered pad data
//  pad_oe      out  NPINS  registered pad output-enable
//  evt_mask    in   NPINS  1 = pin participates in change detection
//  evt_clr     in   NPINS  1-cycle pulse per bit, clears event flag
//  evt         out  NPINS  sticky change-event flags
//  evt_any     out  1      OR of evt, registered
// BEHAVIOUR
//  Reset (nres=0 at clk edge):
//   - core_nres=0; pad_oe=0; pad_out=0; evt=0; evt_any=0; pin_in=0.
//   - All sync stages cleared; hold counter cleared; FSM=RST.
//  Reset FSM, states RST, HOLD, RUN:
//   - RST: core_nres=0. Leaves for HOLD on the first cycle with nres=1 and cfg_rst=0.
//   - HOLD: core_nres=0; counter increments each cycle. At count==HOLD_CYCLES-1 go to RUN, counter cleared.
//   - RUN: core_nres=1.
//   - cfg_rst=1 in HOLD or RUN: go to RST next cycle, counter cleared; core_nres=0 that same next edge.
//   - HOLD_CYCLES=0 is treated as 1.
//   - First core_nres=1 occurs exactly HOLD_CYCLES+1 cycles after the cycle leaving RST.
//  Outputs:
//   - pad_out <= pin_out, pad_oe <= pin_dir; 1-cycle latency.
//   - While core_nres=0: pad_oe forced 0, pad_out forced 0 (pins float during core reset).
//  Inputs:
//   - pad_in passes through SYNC_STAGES flops; pin_in = last stage.
//   - Latency is SYNC_STAGES cycles from pad_in to pin_in.
//   - pin_in stays live during core reset (only nres clears it).
//  Events:
//   - d = pin_in ^ pin_in_q (one extra flop).
//   - evt[i] <= (evt[i] & ~evt_clr[i]) | (d[i] & evt_mask[i]).
//   - Set and clear in the same cycle: set wins.
//   - Masking a pin does not clear its existing flag.
//   - evt_any <= |evt_next (same edge as evt).
//   - Events are cleared whenever core_nres=0; pin_in_q is reloaded so the first RUN cycle does not create a false edge.
// STRUCTURE
//  - Shared package (p1v_pkg): FSM state encoding RST=2'd0, HOLD=2'd1, RUN=2'd2; default NPINS.
//  - One sub-module, io_sync: a parametrised SYNC_STAGES x NPINS synchroniser chain with synchronous active-low clear.
//  - Reset FSM, pad registers and event logic stay in io_reset_ctl.
// TESTING
//  1. nres low 3 cycles then high, HOLD_CYCLES=4 -> core_nres=0 for 5 cycles after release, then 1; pad_oe=0 throughout.
//  2. In RUN, pin_dir=0xFFFF0000, pin_out=0xA5A5A5A5 -> next cycle pad_oe=0xFFFF0000, pad_out=0xA5A5A5A5.
//  3. In RUN, pulse cfg_rst 1 cycle -> core_nres=0 next cycle, pad_oe=0, evt=0; core_nres back to 1 after HOLD_CYCLES+1 cycles.
//  4. pad_in[3] 0->1, evt_mask=0x8 -> pin_in[3] rises after 2 cycles; evt=0x8 and evt_any=1 one cycle later.
//  5. evt_clr[3] pulse in the same cycle as a new pin-3 edge -> evt[3] stays 1. A later lone clr -> evt[3]=0, evt_any=0.
//  6. nres low during HOLD with count=2 -> FSM=RST, counter=0; pin_in=0 next cycle; HOLD restarts from 0 on release.

Source files
------------

// File: rtl/p1v_pkg.sv
// Shared definitions for the pin-ring / core-reset slice.
// Reset FSM encoding and default pin count.
package p1v_pkg;

   typedef enum logic [1:0] {
      RST  = 2'd0,
      HOLD = 2'd1,
      RUN  = 2'd2
   } rst_state_t;

   localparam int NPINS_DEF = 32;

endpackage

// File: rtl/io_sync.sv
// Multi-stage synchroniser for raw pad inputs.
// Synchronous active-low clear empties every stage.
module io_sync #(
   parameter int STAGES = 2,
   parameter int W      = 32
) (
   input  logic         clk_cog,
   input  logic         clr_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] sr [STAGES];

   always_ff @(posedge clk_cog) begin
      if (!clr_n) begin
         for (int i = 0; i < STAGES; i++) sr[i] <= '0;
      end else begin
         sr[0] <= d;
         for (int i = 1; i < STAGES; i++) sr[i] <= sr[i-1];
      end
   end

   assign q = sr[STAGES-1];

endmodule

// File: rtl/io_reset_ctl.sv
// Pin-ring and stretched core-reset controller.
// Drives pad data/enable, synchronises pad inputs, latches pin events.
module io_reset_ctl
   import p1v_pkg::*;
#(
   parameter int NPINS       = NPINS_DEF,
   parameter int SYNC_STAGES = 2,
   parameter int HOLD_W      = 24,
   parameter int HOLD_CYCLES = 1024
) (
   input  logic             clk_cog,
   input  logic             nres,
   input  logic             cfg_rst,
   output logic             core_nres,
   input  logic [NPINS-1:0] pin_out,
   input  logic [NPINS-1:0] pin_dir,
   output logic [NPINS-1:0] pin_in,
   input  logic [NPINS-1:0] pad_in,
   output logic [NPINS-1:0] pad_out,
   output logic [NPINS-1:0] pad_oe,
   input  logic [NPINS-1:0] evt_mask,
   input  logic [NPINS-1:0] evt_clr,
   output logic [NPINS-1:0] evt,
   output logic             evt_any
);

   // A zero hold request still spends one cycle in HOLD
   localparam logic [HOLD_W-1:0] HOLD_LAST =
      (HOLD_CYCLES == 0) ? '0 : HOLD_W'(HOLD_CYCLES - 1);

   rst_state_t       state, state_nxt;
   logic [HOLD_W-1:0] cnt, cnt_nxt;
   logic             run_nxt;
   logic [NPINS-1:0] pin_in_q;
   logic [NPINS-1:0] evt_nxt;
   logic [NPINS-1:0] edge_d;

   always_ff @(posedge clk_cog) begin
      if (!nres) begin
         state <= RST;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = '0;
      unique case (state)
         RST: begin
            if (!cfg_rst) state_nxt = HOLD;
         end
         HOLD: begin
            if (cfg_rst)                state_nxt = RST;
            else if (cnt == HOLD_LAST)  state_nxt = RUN;
            else                        cnt_nxt   = cnt + 1'b1;
         end
         RUN: begin
            if (cfg_rst) state_nxt = RST;
         end
         default: state_nxt = RST;
      endcase
   end

   always_comb begin
      run_nxt = (state_nxt == RUN);
   end

   io_sync #(
      .STAGES (SYNC_STAGES),
      .W      (NPINS)
   ) u_sync (
      .clk_cog (clk_cog),
      .clr_n   (nres),
      .d       (pad_in),
      .q       (pin_in)
   );

   // Events only accumulate while the core is out of reset
   assign edge_d = pin_in ^ pin_in_q;

   always_comb begin
      evt_nxt = '0;
      if (run_nxt) evt_nxt = (evt & ~evt_clr) | (edge_d & evt_mask);
   end

   always_ff @(posedge clk_cog) begin
      if (!nres) begin
         core_nres <= 1'b0;
         pad_out   <= '0;
         pad_oe    <= '0;
         pin_in_q  <= '0;
         evt       <= '0;
         evt_any   <= 1'b0;
      end else begin
         core_nres <= run_nxt;
         pad_out   <= run_nxt ? pin_out : '0;
         pad_oe    <= run_nxt ? pin_dir : '0;
         pin_in_q  <= pin_in;
         evt       <= evt_nxt;
         evt_any   <= |evt_nxt;
      end
   end

endmodule

// File: tb/tb_io_reset_ctl.sv
// Self-checking bench for io_reset_ctl.
// Directed scenarios plus randomized traffic against a behavioural model.
module tb_io_reset_ctl;

   localparam int NP   = 32;
   localparam int SS   = 2;
   localparam int HW   = 24;
   localparam int HC   = 4;
   localparam int HEFF = (HC == 0) ? 1 : HC;
   localparam int HMAX = 8192;

   logic          clk_cog = 1'b0;
   logic          nres    = 1'b0;
   logic          cfg_rst = 1'b0;
   logic [NP-1:0] pin_out  = '0;
   logic [NP-1:0] pin_dir  = '0;
   logic [NP-1:0] pad_in   = '0;
   logic [NP-1:0] evt_mask = '0;
   logic [NP-1:0] evt_clr  = '0;
   logic          core_nres;
   logic [NP-1:0] pin_in;
   logic [NP-1:0] pad_out;
   logic [NP-1:0] pad_oe;
   logic [NP-1:0] evt;
   logic          evt_any;

   io_reset_ctl #(
      .NPINS       (NP),
      .SYNC_STAGES (SS),
      .HOLD_W      (HW),
      .HOLD_CYCLES (HC)
   ) dut (
      .clk_cog   (clk_cog),
      .nres      (nres),
      .cfg_rst   (cfg_rst),
      .core_nres (core_nres),
      .pin_out   (pin_out),
      .pin_dir   (pin_dir),
      .pin_in    (pin_in),
      .pad_in    (pad_in),
      .pad_out   (pad_out),
      .pad_oe    (pad_oe),
      .evt_mask  (evt_mask),
      .evt_clr   (evt_clr),
      .evt       (evt),
      .evt_any   (evt_any)
   );

   always #5 clk_cog = ~clk_cog;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h t=%0t",
                  name, act, exp, $time);
      end
   endtask

   // Behavioural model: core runs once HEFF+1 consecutive clean cycles seen
   int            streak = 0;
   int            n      = 0;
   logic [NP-1:0] pad_hist [HMAX];
   bit            nres_hist [HMAX];
   logic          m_core = 1'b0;
   logic [NP-1:0] m_pin  = '0;
   logic [NP-1:0] m_pinq = '0;
   logic [NP-1:0] m_evt  = '0;
   logic          m_any  = 1'b0;
   logic [NP-1:0] m_pout = '0;
   logic [NP-1:0] m_poe  = '0;
   logic [NP-1:0] d_m;
   bit            ok;

   always @(posedge clk_cog) begin
      if (nres && !cfg_rst) begin
         if (streak < 100000) streak = streak + 1;
      end else begin
         streak = 0;
      end
      m_core = nres && (streak >= HEFF + 1);
      pad_hist[n]  = pad_in;
      nres_hist[n] = nres;
      ok = 1'b1;
      for (int k = 0; k < SS; k++) begin
         if (n - k < 0) ok = 1'b0;
         else if (!nres_hist[n-k]) ok = 1'b0;
      end
      d_m    = m_pin ^ m_pinq;
      m_pinq = nres ? m_pin : '0;
      m_pin  = ok ? pad_hist[n-SS+1] : '0;
      m_evt  = m_core ? ((m_evt & ~evt_clr) | (d_m & evt_mask)) : '0;
      m_any  = |m_evt;
      m_pout = m_core ? pin_out : '0;
      m_poe  = m_core ? pin_dir : '0;
      n++;
      #1;
      chk("m_core_nres", {31'd0, core_nres}, {31'd0, m_core});
      chk("m_pin_in",    pin_in,  m_pin);
      chk("m_pad_out",   pad_out, m_pout);
      chk("m_pad_oe",    pad_oe,  m_poe);
      chk("m_evt",       evt,     m_evt);
      chk("m_evt_any",   {31'd0, evt_any}, {31'd0, m_any});
   end

   initial begin
      pad_in = 32'h0000_00F0;
      repeat (3) @(negedge clk_cog);
      chk("rst_core", {31'd0, core_nres}, 0);
      chk("rst_oe",   pad_oe, 0);
      chk("rst_out",  pad_out, 0);
      chk("rst_pin",  pin_in, 0);
      chk("rst_evt",  evt, 0);

      // release: 4 hold cycles low after the leaving cycle, then run
      pin_dir = '1;
      pin_out = '1;
      nres    = 1'b1;
      for (int i = 0; i < HEFF; i++) begin
         @(negedge clk_cog);
         chk("t1_hold_core", {31'd0, core_nres}, 0);
         chk("t1_hold_oe",   pad_oe, 0);
      end
      @(negedge clk_cog);
      chk("t1_run_core", {31'd0, core_nres}, 1);
      chk("t1_run_oe",   pad_oe, 32'hFFFF_FFFF);

      pin_dir = 32'hFFFF_0000;
      pin_out = 32'hA5A5_A5A5;
      @(negedge clk_cog);
      chk("t2_oe",  pad_oe,  32'hFFFF_0000);
      chk("t2_out", pad_out, 32'hA5A5_A5A5);
      chk("t2_model_oe", m_poe, 32'hFFFF_0000);

      cfg_rst = 1'b1;
      @(negedge clk_cog);
      chk("t3_core", {31'd0, core_nres}, 0);
      chk("t3_oe",   pad_oe, 0);
      chk("t3_evt",  evt, 0);
      cfg_rst = 1'b0;
      for (int i = 0; i < HEFF; i++) begin
         @(negedge clk_cog);
         chk("t3_hold_core", {31'd0, core_nres}, 0);
      end
      @(negedge clk_cog);
      chk("t3_run_core", {31'd0, core_nres}, 1);

      evt_mask = 32'h8;
      pad_in   = 32'h0000_00F8;
      @(negedge clk_cog);
      chk("t4_pin3_early", pin_in & 32'h8, 0);
      @(negedge clk_cog);
      chk("t4_pin3", pin_in & 32'h8, 32'h8);
      chk("t4_evt_early", evt, 0);
      @(negedge clk_cog);
      chk("t4_evt", evt, 32'h8);
      chk("t4_any", {31'd0, evt_any}, 1);
      chk("t4_model_evt", m_evt, 32'h8);

      // new falling edge on pin 3 with a clear in the same cycle
      pad_in = 32'h0000_00F0;
      repeat (2) @(negedge clk_cog);
      chk("t5_pin3_low", pin_in & 32'h8, 0);
      evt_clr = 32'h8;
      @(negedge clk_cog);
      chk("t5_set_wins", evt, 32'h8);
      @(negedge clk_cog);
      chk("t5_lone_clr", evt, 0);
      chk("t5_any", {31'd0, evt_any}, 0);
      evt_clr = '0;

      cfg_rst = 1'b1;
      @(negedge clk_cog);
      cfg_rst = 1'b0;
      repeat (3) @(negedge clk_cog);
      chk("t6_pin_live", pin_in, 32'h0000_00F0);
      nres = 1'b0;
      @(negedge clk_cog);
      chk("t6_pin_clr", pin_in, 0);
      chk("t6_core", {31'd0, core_nres}, 0);
      nres = 1'b1;
      for (int i = 0; i < HEFF; i++) begin
         @(negedge clk_cog);
         chk("t6_hold_core", {31'd0, core_nres}, 0);
      end
      @(negedge clk_cog);
      chk("t6_run_core", {31'd0, core_nres}, 1);

      for (int c = 0; c < 1500; c++) begin
         nres     = ($urandom_range(0, 99) != 0);
         cfg_rst  = ($urandom_range(0, 59) == 0);
         pad_in   = pad_in ^ ($urandom & $urandom & $urandom);
         pin_out  = $urandom;
         pin_dir  = $urandom;
         evt_mask = $urandom;
         evt_clr  = $urandom & $urandom & $urandom;
         @(negedge clk_cog);
      end

      @(negedge clk_cog);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
